// File: rtl/hls_perf_counter_bank_if.sv
// Register-port and handshake bundle for hls_perf_counter_bank.
// Latency: none, wires only.
// Backpressure: only the optional trace stream has any, through trace_ready.
// Ports (master drives the monitor, slave is the monitor):
//   clear, ch_start, ch_done, ch_continue, iter_enable, iter_block   monitor inputs
//   rd_en, rd_ch, rd_sel -> rd_data, rd_valid                        register read port
//   overflow, busy                                                   per-channel status
//   trace_valid/ready/data/drop                                      only with HLS_PERF_TRACE_EN
interface hls_perf_counter_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
`ifdef HLS_PERF_TRACE_EN
  ,
  parameter int TS_W   = 32
`endif
);
  localparam int RCH_W = $clog2(NUM_CH) + 1;

  logic              clear;
  logic [NUM_CH-1:0] ch_start;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] ch_continue;
  logic [NUM_CH-1:0] iter_enable;
  logic [NUM_CH-1:0] iter_block;
  logic              rd_en;
  logic [RCH_W-1:0]  rd_ch;
  logic [2:0]        rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic [NUM_CH-1:0] overflow;
  logic [NUM_CH-1:0] busy;

`ifdef HLS_PERF_TRACE_EN
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TRC_W = TS_W + CH_W + 2;

  logic              trace_valid;
  logic              trace_ready;
  logic [TRC_W-1:0]  trace_data;
  logic              trace_drop;

  modport master (
    output clear, ch_start, ch_done, ch_continue, iter_enable, iter_block,
    output rd_en, rd_ch, rd_sel, trace_ready,
    input  rd_data, rd_valid, overflow, busy, trace_valid, trace_data, trace_drop
  );
  modport slave (
    input  clear, ch_start, ch_done, ch_continue, iter_enable, iter_block,
    input  rd_en, rd_ch, rd_sel, trace_ready,
    output rd_data, rd_valid, overflow, busy, trace_valid, trace_data, trace_drop
  );
`else
  modport master (
    output clear, ch_start, ch_done, ch_continue, iter_enable, iter_block,
    output rd_en, rd_ch, rd_sel,
    input  rd_data, rd_valid, overflow, busy
  );
  modport slave (
    input  clear, ch_start, ch_done, ch_continue, iter_enable, iter_block,
    input  rd_en, rd_ch, rd_sel,
    output rd_data, rd_valid, overflow, busy
  );
`endif
endinterface

// File: rtl/hls_perf_counter_bank.sv
// Per-channel performance counters for HLS ap_start/ap_done/ap_continue handshakes.
// Latency: counters update on the event cycle; a read returns data one cycle after rd_en.
// Backpressure: none on monitored signals; trace entries are dropped when the FIFO is full.
// Ports: clock, reset (sync, active-high), bus (hls_perf_counter_bank_if.slave).
// Optional trace stream of start/done events: define HLS_PERF_TRACE_EN.
// Counter select on rd_sel: 0 inv, 1 iter, 2 stall, 3 last_lat, 4 max_lat, 5 busy_cyc, 6 state, 7 zero.

`ifdef HLS_PERF_TRACE_EN
// Small first-word-fall-through FIFO holding trace entries.
// Latency: a pushed entry is visible at dout on the next cycle.
// Backpressure: full is reported, a push while full is ignored.
module hls_perf_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule
`endif

module hls_perf_counter_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32
`ifdef HLS_PERF_TRACE_EN
  ,
  parameter int TS_W        = 32,
  parameter int TRACE_DEPTH = 16
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  hls_perf_counter_bank_if.slave bus
);
  localparam int              RCH_W   = $clog2(NUM_CH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t            state_q  [NUM_CH];
  state_t            state_d  [NUM_CH];
  logic [NUM_CH-1:0] start_evt, done_evt;
  logic [NUM_CH-1:0] busy_inc, iter_inc, stall_inc, lat_inc, ovf_hit;
  logic [CNT_W-1:0]  lat_q    [NUM_CH];
  logic [CNT_W-1:0]  done_lat [NUM_CH];
  logic [CNT_W-1:0]  inv_cnt  [NUM_CH];
  logic [CNT_W-1:0]  iter_cnt [NUM_CH];
  logic [CNT_W-1:0]  stall_cnt[NUM_CH];
  logic [CNT_W-1:0]  last_lat [NUM_CH];
  logic [CNT_W-1:0]  max_lat  [NUM_CH];
  logic [CNT_W-1:0]  busy_cyc [NUM_CH];
  logic [NUM_CH-1:0] overflow_q;
  logic [NUM_CH-1:0] busy_vec;
  logic [CNT_W-1:0]  rd_mux;
  logic [CNT_W-1:0]  rd_data_q;
  logic              rd_valid_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Channel FSMs. A start that coincides with a completing done (from RUN or HOLD)
  // opens the next invocation in the same cycle. Done together with start in IDLE
  // is a one-cycle invocation of latency 1.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c]   = state_q[c];
      start_evt[c] = 1'b0;
      done_evt[c]  = 1'b0;
      // lat_q lags the invocation by one cycle, so the done cycle adds one.
      done_lat[c]  = sat_inc(lat_q[c]);
      case (state_q[c])
        IDLE: begin
          if (bus.ch_start[c]) begin
            start_evt[c] = 1'b1;
            if (bus.ch_done[c]) begin
              done_evt[c] = 1'b1;
              done_lat[c] = CNT_ONE;
              state_d[c]  = bus.ch_continue[c] ? IDLE : HOLD;
            end else begin
              state_d[c]  = RUN;
            end
          end
        end
        RUN: begin
          if (bus.ch_done[c]) begin
            done_evt[c] = 1'b1;
            if (!bus.ch_continue[c]) begin
              state_d[c] = HOLD;
            end else if (bus.ch_start[c]) begin
              start_evt[c] = 1'b1;
              state_d[c]   = RUN;
            end else begin
              state_d[c]   = IDLE;
            end
          end
        end
        HOLD: begin
          if (bus.ch_continue[c]) begin
            if (bus.ch_start[c]) begin
              start_evt[c] = 1'b1;
              state_d[c]   = RUN;
            end else begin
              state_d[c]   = IDLE;
            end
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  // Increment qualifiers and saturation detection. busy_cyc counts every cycle of
  // an invocation, including the start cycle, so it agrees with the latency.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      busy_inc[c]  = (state_q[c] != IDLE) || start_evt[c];
      iter_inc[c]  = (state_q[c] == RUN) && bus.iter_enable[c] && !bus.iter_block[c];
      stall_inc[c] = (state_q[c] == RUN) && bus.iter_block[c];
      lat_inc[c]   = (state_q[c] == RUN) && !start_evt[c];
      ovf_hit[c]   = (start_evt[c] && inv_cnt[c]   == CNT_MAX) ||
                     (iter_inc[c]  && iter_cnt[c]  == CNT_MAX) ||
                     (stall_inc[c] && stall_cnt[c] == CNT_MAX) ||
                     (busy_inc[c]  && busy_cyc[c]  == CNT_MAX) ||
                     (lat_inc[c]   && lat_q[c]     == CNT_MAX);
      busy_vec[c]  = (state_q[c] != IDLE);
    end
  end

  // FSM state and the running latency are not touched by clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= IDLE;
        lat_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        if (start_evt[c])    lat_q[c] <= CNT_ONE;
        else if (lat_inc[c]) lat_q[c] <= sat_inc(lat_q[c]);
      end
    end
  end

  // Clear outranks same-cycle events, which are lost.
  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        inv_cnt[c]   <= '0;
        iter_cnt[c]  <= '0;
        stall_cnt[c] <= '0;
        last_lat[c]  <= '0;
        max_lat[c]   <= '0;
        busy_cyc[c]  <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (start_evt[c]) inv_cnt[c]   <= sat_inc(inv_cnt[c]);
        if (iter_inc[c])  iter_cnt[c]  <= sat_inc(iter_cnt[c]);
        if (stall_inc[c]) stall_cnt[c] <= sat_inc(stall_cnt[c]);
        if (busy_inc[c])  busy_cyc[c]  <= sat_inc(busy_cyc[c]);
        if (done_evt[c]) begin
          last_lat[c] <= done_lat[c];
          if (done_lat[c] > max_lat[c]) max_lat[c] <= done_lat[c];
        end
      end
      overflow_q <= overflow_q | ovf_hit;
    end
  end

  // Out-of-range channels match no entry and read as zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.rd_ch == RCH_W'(c)) begin
        case (bus.rd_sel)
          3'd0:    rd_mux = inv_cnt[c];
          3'd1:    rd_mux = iter_cnt[c];
          3'd2:    rd_mux = stall_cnt[c];
          3'd3:    rd_mux = last_lat[c];
          3'd4:    rd_mux = max_lat[c];
          3'd5:    rd_mux = busy_cyc[c];
          3'd6:    rd_mux = {{(CNT_W-2){1'b0}}, 2'(state_q[c])};
          default: rd_mux = '0;
        endcase
      end
    end
  end

  // Registered read captures pre-update values; rd_data holds between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_mux;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_vec;

`ifdef HLS_PERF_TRACE_EN
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TRC_W = TS_W + CH_W + 2;

  logic [TS_W-1:0]  ts_q;
  logic             trc_push;
  logic [CH_W-1:0]  trc_ch;
  logic [1:0]       trc_evt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TRC_W-1:0] fifo_dout;
  logic             drop_q;

  always_ff @(posedge clock) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end

  // Lowest channel with an event wins; evt = {done, start}.
  always_comb begin
    trc_push = 1'b0;
    trc_ch   = '0;
    trc_evt  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!trc_push && (start_evt[c] || done_evt[c])) begin
        trc_push = 1'b1;
        trc_ch   = CH_W'(c);
        trc_evt  = {done_evt[c], start_evt[c]};
      end
    end
  end

  hls_perf_trace_fifo #(.W(TRC_W), .DEPTH(TRACE_DEPTH)) u_trace_fifo (
    .clock (clock),
    .reset (reset),
    .flush (bus.clear),
    .push  (trc_push && !bus.clear),
    .din   ({ts_q, trc_ch, trc_evt}),
    .pop   (bus.trace_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A push into a full FIFO is dropped even if a pop frees a slot that cycle.
  always_ff @(posedge clock) begin
    if (reset) drop_q <= 1'b0;
    else       drop_q <= trc_push && !bus.clear && fifo_full;
  end

  assign bus.trace_valid = !fifo_empty;
  assign bus.trace_data  = fifo_dout;
  assign bus.trace_drop  = drop_q;
`endif
endmodule
